// File: rtl/clz_unit.sv
// Multi-cycle CLZ/CLO unit: scans the operand one nibble per cycle from the MSB
// and returns the leading-zero (or leading-one) count zero-extended to 32 bits.
module clz_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    input  logic [31:0] a,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] op_q;
    logic [5:0]  cnt_q;
    logic [5:0]  res_q;

    logic [3:0]  nib;
    logic [5:0]  cnt_d;
    logic [5:0]  res_d;

    // Leading zeros of a nonzero nibble (0..3).
    function automatic logic [1:0] nib_lz(input logic [3:0] n);
        logic [1:0] lz;
        casez (n)
            4'b1???: lz = 2'd0;
            4'b01??: lz = 2'd1;
            4'b001?: lz = 2'd2;
            default: lz = 2'd3;
        endcase
        return lz;
    endfunction

    always_comb begin
        nib   = op_q[31:28];
        cnt_d = cnt_q + 6'd4;
        res_d = cnt_q + {4'b0000, nib_lz(nib)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= 32'h0;
            cnt_q   <= 6'd0;
            res_q   <= 6'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q    <= mode ? ~a : a;
                        cnt_q   <= 6'd0;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (nib == 4'h0) begin
                        // An all-zero operand terminates after the eighth nibble.
                        if (cnt_d < 6'd32) begin
                            cnt_q <= cnt_d;
                            op_q  <= {op_q[27:0], 4'h0};
                        end else begin
                            res_q   <= 6'd32;
                            state_q <= DONE;
                        end
                    end else begin
                        res_q   <= res_d;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = (state_q == SCAN);
    assign done   = (state_q == DONE);
    assign result = {26'h0, res_q};

endmodule

// File: tb/tb_clz_unit.sv
// Scoreboard bench for clz_unit: directed operands with hand-computed counts
// and scan lengths, checked by an independent done-driven monitor.
module tb_clz_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        mode;
    logic [31:0] a;
    logic        busy;
    logic        done;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        int          scans;
    } exp_t;

    typedef struct {
        logic        mode;
        logic [31:0] a;
        logic [31:0] res;
        int          scans;
    } vec_t;

    exp_t sb[$];
    int   n_vec;
    int   n_err;
    int   busy_cnt;

    clz_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mode   (mode),
        .a      (a),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: counts busy cycles and scores each done pulse against the queue.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("result", result, e.res);
                    check("scan_cycles", 32'(busy_cnt), 32'(e.scans));
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic issue(input logic m, input logic [31:0] op, input logic [31:0] res, input int scans);
        exp_t e;
        e.res   = res;
        e.scans = scans;
        sb.push_back(e);
        start = 1'b1;
        mode  = m;
        a     = op;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 32'hDEAD_BEEF;
        mode  = ~m;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            check("timeout_pending", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    vec_t vecs[8];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec    = 0;
        n_err    = 0;
        busy_cnt = 0;
        rst      = 1'b1;
        start    = 1'b0;
        mode     = 1'b0;
        a        = 32'h0;

        vecs[0] = '{1'b0, 32'h0000_0000, 32'd32, 8};
        vecs[1] = '{1'b0, 32'h0001_0000, 32'd15, 4};
        vecs[2] = '{1'b0, 32'h8000_0000, 32'd0,  1};
        vecs[3] = '{1'b1, 32'hFFFF_FFFF, 32'd32, 8};
        vecs[4] = '{1'b1, 32'hF000_0000, 32'd4,  2};
        vecs[5] = '{1'b0, 32'h0000_0001, 32'd31, 8};
        vecs[6] = '{1'b0, 32'h0700_0000, 32'd5,  2};
        vecs[7] = '{1'b1, 32'hFFF0_1234, 32'd12, 4};

        // Reset state before any clock edge.
        #3;
        check("rst_busy",   {31'd0, busy}, 32'd0);
        check("rst_done",   {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            issue(vecs[i].mode, vecs[i].a, vecs[i].res, vecs[i].scans);
            wait_idle();
        end

        // Start while busy must be ignored; result holds until the new DONE.
        issue(1'b0, 32'h0000_0000, 32'd32, 8);
        @(posedge clk);
        #1;
        check("busy_mid_scan", {31'd0, busy}, 32'd1);
        check("hold_mid_scan", result, 32'd12);
        start = 1'b1;
        mode  = 1'b0;
        a     = 32'h0000_0001;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("hold_after_done", result, 32'd32);
            check("no_extra_done", {31'd0, done}, 32'd0);
        end

        // Reset asserted in the third SCAN cycle aborts with no done pulse.
        start = 1'b1;
        mode  = 1'b0;
        a     = 32'h0000_0000;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("busy_before_abort", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_busy",   {31'd0, busy}, 32'd0);
        check("abort_done",   {31'd0, done}, 32'd0);
        check("abort_result", result, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
        end
        check("post_abort_result", result, 32'd0);

        // Back-to-back requests after reset release.
        issue(1'b0, 32'h00FF_0000, 32'd8, 3);
        wait_idle();
        issue(1'b1, 32'h8000_0000, 32'd1, 1);
        wait_idle();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        check("final_result", result, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/clz_unit.md
CLZ_UNIT -- requirements
Module: clz_unit

Purpose: multi-cycle leading-zero / leading-one counter (MIPS CLZ/CLO). Reduces a 32-bit operand to a count, returned zero-extended to 32 bits.

Interface
Parameters: none.
REQ-001 clk  input  1  system clock; all state changes on the rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 start  input  1  request pulse; sampled only in IDLE.
REQ-004 mode  input  1  0 = count leading zeros (CLZ), 1 = count leading ones (CLO); sampled with start.
REQ-005 a  input  32  operand; sampled with start.
REQ-006 busy  output  1  high while a scan is in progress (state SCAN).
REQ-007 done  output  1  one-cycle completion pulse (state DONE).
REQ-008 result  output  32  count 0..32 in bits [5:0]; bits [31:6] always 0.

Function
REQ-009 The FSM SHALL have three states: IDLE, SCAN and DONE.
REQ-010 In IDLE, when start=1 at a rising edge, the block SHALL latch the working operand and go to SCAN.
  - Working operand = a when mode=0, ~a when mode=1.
  - The internal count is cleared to 0 at the same edge.
REQ-011 In IDLE, when start=0, the block SHALL stay in IDLE.
REQ-012 In SCAN, each rising edge SHALL examine the top nibble [31:28] of the working operand.
REQ-013 If that nibble is 0 and count+4 < 32, the block SHALL add 4 to the count, shift the operand left by 4 and stay in SCAN.
REQ-014 If that nibble is 0 and count+4 = 32, the block SHALL load result = 32 and go to DONE.
REQ-015 If that nibble is nonzero, the block SHALL load result = count + (leading zeros of the nibble, 0..3) and go to DONE.
REQ-016 The number of SCAN cycles SHALL be n = (index of the first nonzero nibble from the MSB) + 1, or 8 if the working operand is 0.
  - done is high during the cycle after the n-th SCAN edge.
  - Total latency from the start-sampling edge to done is n+1 edges.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle and the next edge SHALL return to IDLE.
  - start is ignored in DONE.
  - A back-to-back request may be issued in the IDLE cycle that follows.
REQ-018 In SCAN and DONE, start SHALL be ignored; mode and a SHALL not affect the scan in progress.
REQ-019 result SHALL hold its value from the DONE-entry edge until the next DONE entry or reset.
REQ-020 busy SHALL equal (state==SCAN) and done SHALL equal (state==DONE); both are registered-state decodes with no combinational path from the inputs.
REQ-021 The count SHALL never exceed 32, and result[31:6] SHALL be constant 0.

Reset
REQ-022 When rst=1, regardless of clk, the block SHALL immediately force state=IDLE, busy=0, done=0 and result=0, and clear the working operand and count.
REQ-023 A reset during SCAN or DONE SHALL abort the operation: no done pulse, result=0.
REQ-024 After rst deasserts, the first rising edge with start=1 SHALL begin a new operation.

Verification
REQ-025 mode=0, a=0x0000_0000, start pulse -> 8 SCAN cycles with busy=1, then done=1 with result=32.
REQ-026 mode=0, a=0x0001_0000 -> 4 SCAN cycles, then done with result=15; mode=0, a=0x8000_0000 -> 1 SCAN cycle, then result=0.
REQ-027 mode=1, a=0xFFFF_FFFF -> result=32 after 8 SCAN cycles; mode=1, a=0xF000_0000 -> 2 SCAN cycles, then result=4.
REQ-028 Apply start with a=0x0000_0001 while busy=1 in a previous scan -> the second request is ignored, and the previous result is correct and stable.
REQ-029 Assert rst in the 3rd SCAN cycle of a=0 -> busy=0, done=0, result=0 immediately, and no done pulse follows.
REQ-030 Two back-to-back requests (mode=0, a=0x00FF_0000 then mode=1, a=0x8000_0000) -> results 8 then 1, each with a single done pulse.
